// File: rtl/shift_pkg.sv
// Shared types and RV32I encoding constants for the shift operand stage.
package shift_pkg;

   typedef enum logic [1:0] {
      OpSll = 2'd0,
      OpSrl = 2'd1,
      OpSra = 2'd2
   } shift_op_e;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SR      = 3'b101;
   localparam logic [6:0] F7_ZERO    = 7'b0000000;
   localparam logic [6:0] F7_SRA     = 7'b0100000;

   typedef struct packed {
      logic [31:0] a;
      logic [4:0]  shamt;
      shift_op_e   op;
      logic [4:0]  rd;
      logic        illegal;
   } shift_req_t;

endpackage

// File: rtl/shift_decode.sv
// Combinational decode of an RV32I word into a shift request.
module shift_decode
   import shift_pkg::*;
(
   input  logic [31:0] i_instr,
   input  logic [31:0] i_rs1_data,
   input  logic [31:0] i_rs2_data,
   output shift_req_t  o_req
);

   logic [6:0] w_opc;
   logic [2:0] w_f3;
   logic [6:0] w_f7;
   logic       w_is_op;
   logic       w_is_imm;

   assign w_opc    = i_instr[6:0];
   assign w_f3     = i_instr[14:12];
   assign w_f7     = i_instr[31:25];
   assign w_is_op  = (w_opc == OPC_OP);
   assign w_is_imm = (w_opc == OPC_OP_IMM);

   always_comb begin
      o_req         = '0;
      o_req.op      = OpSll;
      o_req.rd      = i_instr[11:7];
      o_req.illegal = 1'b1;
      if (w_is_op || w_is_imm) begin
         // f7 is compared whole, so an OP-IMM word with instr[25] set is rejected
         if (w_f3 == F3_SLL && w_f7 == F7_ZERO) begin
            o_req.op      = OpSll;
            o_req.illegal = 1'b0;
         end else if (w_f3 == F3_SR && w_f7 == F7_ZERO) begin
            o_req.op      = OpSrl;
            o_req.illegal = 1'b0;
         end else if (w_f3 == F3_SR && w_f7 == F7_SRA) begin
            o_req.op      = OpSra;
            o_req.illegal = 1'b0;
         end
      end
      if (!o_req.illegal) begin
         o_req.a     = i_rs1_data;
         o_req.shamt = w_is_op ? i_rs2_data[4:0] : i_instr[24:20];
      end
   end

endmodule

// File: rtl/shift_operand_stage.sv
// Registered shift operand stage: decode feeding a 2-entry skid buffer with registered ready.
module shift_operand_stage
   import shift_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_flush,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic [31:0] i_instr,
   input  logic [31:0] i_rs1_data,
   input  logic [31:0] i_rs2_data,
   output logic        o_valid,
   input  logic        i_ready,
   output logic [31:0] o_a,
   output logic [4:0]  o_shamt,
   output logic [1:0]  o_op,
   output logic [4:0]  o_rd,
   output logic        o_illegal
);

   typedef enum logic [1:0] {
      StEmpty = 2'd0,
      StOne   = 2'd1,
      StFull  = 2'd2
   } buf_state_e;

   buf_state_e r_state;
   shift_req_t r_out;
   shift_req_t r_skid;
   logic       r_valid;
   logic       r_ready;

   shift_req_t w_dec;
   logic       w_enq;
   logic       w_deq;

   shift_decode u_decode (
      .i_instr    (i_instr),
      .i_rs1_data (i_rs1_data),
      .i_rs2_data (i_rs2_data),
      .o_req      (w_dec)
   );

   assign w_enq = i_valid & r_ready;
   assign w_deq = r_valid & i_ready;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= StEmpty;
         r_valid <= 1'b0;
         r_ready <= 1'b1;
         r_out   <= '0;
         r_skid  <= '0;
      end else if (i_flush) begin
         // Buffered data is left in place; valid going low is enough to drop it
         r_state <= StEmpty;
         r_valid <= 1'b0;
         r_ready <= 1'b1;
      end else begin
         unique case (r_state)
            StEmpty: begin
               if (w_enq) begin
                  r_out   <= w_dec;
                  r_valid <= 1'b1;
                  r_state <= StOne;
               end
            end
            StOne: begin
               if (w_enq && !w_deq) begin
                  r_skid  <= w_dec;
                  r_ready <= 1'b0;
                  r_state <= StFull;
               end else if (w_enq && w_deq) begin
                  r_out   <= w_dec;
               end else if (w_deq) begin
                  r_valid <= 1'b0;
                  r_state <= StEmpty;
               end
            end
            StFull: begin
               if (w_deq) begin
                  r_out   <= r_skid;
                  r_ready <= 1'b1;
                  r_state <= StOne;
               end
            end
            default: begin
               r_state <= StEmpty;
               r_valid <= 1'b0;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   assign o_ready   = r_ready;
   assign o_valid   = r_valid;
   assign o_a       = r_out.a;
   assign o_shamt   = r_out.shamt;
   assign o_op      = r_out.op;
   assign o_rd      = r_out.rd;
   assign o_illegal = r_out.illegal;

endmodule

// File: tb/tb_shift_operand_stage.sv
// Directed self-checking bench for shift_operand_stage.
module tb_shift_operand_stage;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready_o;
   logic [31:0] instr;
   logic [31:0] rs1;
   logic [31:0] rs2;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] a;
   logic [4:0]  shamt;
   logic [1:0]  op;
   logic [4:0]  rd;
   logic        illegal;

   int n_vec = 0;
   int n_err = 0;

   localparam logic [31:0] SLLI_X5 = 32'h0033_1293;

   shift_operand_stage dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_flush    (flush),
      .i_valid    (in_valid),
      .o_ready    (in_ready_o),
      .i_instr    (instr),
      .i_rs1_data (rs1),
      .i_rs2_data (rs2),
      .o_valid    (out_valid),
      .i_ready    (out_ready),
      .o_a        (a),
      .o_shamt    (shamt),
      .o_op       (op),
      .o_rd       (rd),
      .o_illegal  (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      instr = '0; rs1 = '0; rs2 = '0;
      step(); step();
      rst_n = 1'b1;
      n_vec++;
      if ({in_ready_o, out_valid, a, shamt, op, rd, illegal} !== {1'b1, 1'b0, 32'h0, 5'd0, 2'd0, 5'd0, 1'b0}) begin
         n_err++;
         $display("FAIL reset: got rdy=%b vld=%b a=%h sh=%0d op=%0d rd=%0d ill=%b, want rdy=1 vld=0 rest 0",
                  in_ready_o, out_valid, a, shamt, op, rd, illegal);
      end
   endtask

   task automatic test_decode();
      logic [31:0] t_instr [8];
      logic [31:0] t_rs1   [8];
      logic [31:0] t_rs2   [8];
      logic [45:0] t_exp   [8];
      logic [45:0] got;
      t_instr[0] = 32'h0033_1293; t_rs1[0] = 32'h0000_0001; t_rs2[0] = 32'hDEAD_BEEF;
      t_exp[0] = {1'b1, 32'h0000_0001, 5'd3, 2'd0, 5'd5, 1'b0};
      t_instr[1] = 32'h4031_50B3; t_rs1[1] = 32'h8000_0000; t_rs2[1] = 32'hFFFF_FFE4;
      t_exp[1] = {1'b1, 32'h8000_0000, 5'd4, 2'd2, 5'd1, 1'b0};
      t_instr[2] = 32'h01F0_D113; t_rs1[2] = 32'h1234_5678; t_rs2[2] = 32'h0;
      t_exp[2] = {1'b1, 32'h1234_5678, 5'd31, 2'd1, 5'd2, 1'b0};
      t_instr[3] = 32'h41F0_D113; t_rs1[3] = 32'hF000_0000; t_rs2[3] = 32'h0;
      t_exp[3] = {1'b1, 32'hF000_0000, 5'd31, 2'd2, 5'd2, 1'b0};
      t_instr[4] = 32'h0094_13B3; t_rs1[4] = 32'hCAFE_F00D; t_rs2[4] = 32'h0000_0025;
      t_exp[4] = {1'b1, 32'hCAFE_F00D, 5'd5, 2'd0, 5'd7, 1'b0};
      t_instr[5] = 32'h0031_00B3; t_rs1[5] = 32'h0000_0055; t_rs2[5] = 32'h0000_0003;
      t_exp[5] = {1'b1, 32'h0, 5'd0, 2'd0, 5'd1, 1'b1};
      t_instr[6] = 32'h0233_1293; t_rs1[6] = 32'h0000_0055; t_rs2[6] = 32'h0000_0003;
      t_exp[6] = {1'b1, 32'h0, 5'd0, 2'd0, 5'd5, 1'b1};
      t_instr[7] = 32'h0031_50B3; t_rs1[7] = 32'h0F0F_0F0F; t_rs2[7] = 32'hFFFF_FFFF;
      t_exp[7] = {1'b1, 32'h0F0F_0F0F, 5'd31, 2'd1, 5'd1, 1'b0};
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; instr = t_instr[i]; rs1 = t_rs1[i]; rs2 = t_rs2[i];
         step();
         got = {out_valid, a, shamt, op, rd, illegal};
         n_vec++;
         if (got !== t_exp[i]) begin
            n_err++;
            $display("FAIL decode[%0d]: got vld/a/sh/op/rd/ill=%h, want %h", i, got, t_exp[i]);
         end
      end
      in_valid = 1'b0;
      step();
      n_vec++;
      if (out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL decode_drain: got vld=%b, want 0", out_valid);
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0; instr = SLLI_X5; rs2 = '0;
      in_valid = 1'b1; rs1 = 32'hA1;
      step();
      n_vec++;
      if ({out_valid, in_ready_o, a} !== {1'b1, 1'b1, 32'hA1}) begin
         n_err++;
         $display("FAIL bp_first: got vld=%b rdy=%b a=%h, want 1 1 a1", out_valid, in_ready_o, a);
      end
      rs1 = 32'hA2;
      step();
      n_vec++;
      if ({out_valid, in_ready_o, a} !== {1'b1, 1'b0, 32'hA1}) begin
         n_err++;
         $display("FAIL bp_full: got vld=%b rdy=%b a=%h, want 1 0 a1", out_valid, in_ready_o, a);
      end
      rs1 = 32'hA3;
      step();
      n_vec++;
      if ({out_valid, in_ready_o, a} !== {1'b1, 1'b0, 32'hA1}) begin
         n_err++;
         $display("FAIL bp_hold: got vld=%b rdy=%b a=%h, want 1 0 a1", out_valid, in_ready_o, a);
      end
      out_ready = 1'b1;
      step();
      n_vec++;
      if ({out_valid, in_ready_o, a} !== {1'b1, 1'b1, 32'hA2}) begin
         n_err++;
         $display("FAIL bp_second: got vld=%b rdy=%b a=%h, want 1 1 a2", out_valid, in_ready_o, a);
      end
      step();
      n_vec++;
      if ({out_valid, in_ready_o, a} !== {1'b1, 1'b1, 32'hA3}) begin
         n_err++;
         $display("FAIL bp_third: got vld=%b rdy=%b a=%h, want 1 1 a3", out_valid, in_ready_o, a);
      end
      in_valid = 1'b0;
      step();
      n_vec++;
      if (out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL bp_drain: got vld=%b, want 0 (duplicate)", out_valid);
      end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1; instr = SLLI_X5;
      for (int k = 0; k < 10; k++) begin
         in_valid = 1'b1; rs1 = 32'h100 + k;
         step();
         n_vec++;
         if ({out_valid, in_ready_o, a} !== {1'b1, 1'b1, 32'h100 + k}) begin
            n_err++;
            $display("FAIL b2b[%0d]: got vld=%b rdy=%b a=%h, want 1 1 %h",
                     k, out_valid, in_ready_o, a, 32'h100 + k);
         end
      end
      in_valid = 1'b0;
      step();
   endtask

   task automatic test_flush();
      out_ready = 1'b0; instr = SLLI_X5;
      in_valid = 1'b1; rs1 = 32'hB1; step();
      rs1 = 32'hB2; step();
      n_vec++;
      if (in_ready_o !== 1'b0) begin
         n_err++;
         $display("FAIL flush_setup: got rdy=%b, want 0", in_ready_o);
      end
      flush = 1'b1; out_ready = 1'b1; rs1 = 32'hB3;
      step();
      n_vec++;
      if ({out_valid, in_ready_o} !== 2'b01) begin
         n_err++;
         $display("FAIL flush: got vld=%b rdy=%b, want 0 1", out_valid, in_ready_o);
      end
      flush = 1'b0; in_valid = 1'b0;
      step();
      n_vec++;
      if (out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL flush_empty: got vld=%b, want 0", out_valid);
      end
      in_valid = 1'b1; rs1 = 32'hB4;
      step();
      in_valid = 1'b0;
      n_vec++;
      if ({out_valid, a} !== {1'b1, 32'hB4}) begin
         n_err++;
         $display("FAIL flush_resume: got vld=%b a=%h, want 1 b4", out_valid, a);
      end
      step();
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0; instr = 32'h403150B3; rs2 = 32'h7;
      in_valid = 1'b1; rs1 = 32'hC1; step();
      rs1 = 32'hC2; step();
      rst_n = 1'b0;
      step();
      n_vec++;
      if ({in_ready_o, out_valid, a, shamt, op, rd, illegal} !== {1'b1, 1'b0, 32'h0, 5'd0, 2'd0, 5'd0, 1'b0}) begin
         n_err++;
         $display("FAIL reset_mid: got rdy=%b vld=%b a=%h sh=%0d op=%0d rd=%0d ill=%b, want 1 0 rest 0",
                  in_ready_o, out_valid, a, shamt, op, rd, illegal);
      end
      rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      step();
      n_vec++;
      if (out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_skid: got vld=%b, want 0 (skid survived reset)", out_valid);
      end
   endtask

   initial begin
      test_reset();
      test_decode();
      test_backpressure();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
